gpr_file: RTL and testbench

- RV64 integer general-purpose register file for the decode stage of the NPC pipeline.
- Two combinational read ports supply rs1/rs2 operands to decode.
- A single internal write port is fed by a fixed-priority arbiter over three write-back sources: EXU, LSU and CSR.
- An a0 (x10) tap feeds the simulation-exit report.

---
 rtl/gpr_file.sv | 94 +++++++++
 tb/tb_gpr_file.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file.sv
// RV64 integer register file: two combinational read ports, one arbitrated write port (EXU > LSU > CSR).
// Define GPR_BYPASS_EN to forward same-cycle write data to the read ports.
module gpr_file #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] rd_exu,
  input  logic [4:0]      rdr_exu,
  input  logic            rd_en_exu,
  input  logic [XLEN-1:0] rd_lsu,
  input  logic [4:0]      rdr_lsu,
  input  logic            rd_en_lsu,
  input  logic [XLEN-1:0] rd_csr,
  input  logic [4:0]      rdr_csr,
  input  logic            rd_en_csr,
  output logic [XLEN-1:0] a0
);

  localparam int unsigned NREGS = 32;
  localparam int unsigned A0_IDX = 10;

  logic [XLEN-1:0] regs [1:NREGS-1];

  logic            wr_en;
  logic [4:0]      wr_idx;
  logic [XLEN-1:0] wr_data;
  logic            wr_fire;

  // Fixed-priority write-back arbiter; losers are dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (rd_en_exu) begin
      wr_en   = 1'b1;
      wr_idx  = rdr_exu;
      wr_data = rd_exu;
    end else if (rd_en_lsu) begin
      wr_en   = 1'b1;
      wr_idx  = rdr_lsu;
      wr_data = rd_lsu;
    end else if (rd_en_csr) begin
      wr_en   = 1'b1;
      wr_idx  = rdr_csr;
      wr_data = rd_csr;
    end
  end

  // x0 has no storage, so writes to it never fire.
  assign wr_fire = rst_n && wr_en && (wr_idx != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_fire) begin
      regs[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rs1 = '0;
    if (rs1_addr != 5'd0) begin
      rs1 = regs[rs1_addr];
`ifdef GPR_BYPASS_EN
      if (wr_fire && (wr_idx == rs1_addr)) begin
        rs1 = wr_data;
      end
`endif
    end
  end

  always_comb begin
    rs2 = '0;
    if (rs2_addr != 5'd0) begin
      rs2 = regs[rs2_addr];
`ifdef GPR_BYPASS_EN
      if (wr_fire && (wr_idx == rs2_addr)) begin
        rs2 = wr_data;
      end
`endif
    end
  end

  // a0 tap reflects stored state only, never bypassed.
  assign a0 = regs[A0_IDX];

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: directed scenarios plus randomized traffic against an array model.
module tb_gpr_file;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      rs1_addr, rs2_addr;
  logic [XLEN-1:0] rs1, rs2, a0;
  logic [XLEN-1:0] rd_exu, rd_lsu, rd_csr;
  logic [4:0]      rdr_exu, rdr_lsu, rdr_csr;
  logic            rd_en_exu, rd_en_lsu, rd_en_csr;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] model [32];

  gpr_file #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1(rs1), .rs2(rs2),
    .rd_exu(rd_exu), .rdr_exu(rdr_exu), .rd_en_exu(rd_en_exu),
    .rd_lsu(rd_lsu), .rdr_lsu(rdr_lsu), .rd_en_lsu(rd_en_lsu),
    .rd_csr(rd_csr), .rdr_csr(rdr_csr), .rd_en_csr(rd_en_csr),
    .a0(a0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Who wins the write port this cycle, by EXU > LSU > CSR priority.
  function automatic void winner(output logic en, output logic [4:0] idx, output logic [XLEN-1:0] d);
    en = 1'b1; idx = 5'd0; d = '0;
    if (rd_en_exu)      begin idx = rdr_exu; d = rd_exu; end
    else if (rd_en_lsu) begin idx = rdr_lsu; d = rd_lsu; end
    else if (rd_en_csr) begin idx = rdr_csr; d = rd_csr; end
    else en = 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] exp_read(input logic [4:0] addr);
    logic en; logic [4:0] idx; logic [XLEN-1:0] d;
    winner(en, idx, d);
    if (addr == 5'd0) return '0;
`ifdef GPR_BYPASS_EN
    if (rst_n && en && idx == addr) return d;
`endif
    return model[addr];
  endfunction

  task automatic clear_wr();
    rd_en_exu = 1'b0; rd_en_lsu = 1'b0; rd_en_csr = 1'b0;
  endtask

  task automatic wr(input int src, input logic [4:0] idx, input logic [XLEN-1:0] d);
    case (src)
      0: begin rd_en_exu = 1'b1; rdr_exu = idx; rd_exu = d; end
      1: begin rd_en_lsu = 1'b1; rdr_lsu = idx; rd_lsu = d; end
      default: begin rd_en_csr = 1'b1; rdr_csr = idx; rd_csr = d; end
    endcase
  endtask

  // Cross one rising edge, commit the winner into the model, return at the falling edge.
  task automatic tick();
    logic en; logic [4:0] idx; logic [XLEN-1:0] d;
    @(posedge clk);
    if (rst_n) begin
      winner(en, idx, d);
      if (en && idx != 5'd0) model[idx] = d;
    end
    @(negedge clk);
    clear_wr();
  endtask

  task automatic check_ports(input string tag);
    #1;
    check({tag, "_rs1"}, rs1, exp_read(rs1_addr));
    check({tag, "_rs2"}, rs2, exp_read(rs2_addr));
    check({tag, "_a0"}, a0, model[10]);
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    rd_exu = '0; rd_lsu = '0; rd_csr = '0;
    rdr_exu = '0; rdr_lsu = '0; rdr_csr = '0;
    clear_wr();
    for (int i = 0; i < 32; i++) model[i] = '0;

    repeat (2) @(negedge clk);
    rs1_addr = 5'd10; rs2_addr = 5'd31; #1;
    check("reset_rs1", rs1, 64'h0);
    check("reset_rs2", rs2, 64'h0);
    check("reset_a0", a0, 64'h0);
    rst_n = 1'b1;

    // Fill x1..x31, then assert reset mid-cycle.
    for (int i = 1; i < 32; i++) begin
      wr(0, 5'(i), 64'hA5A5_0000_0000_0000 | 64'(i));
      tick();
    end
    rs1_addr = 5'd10; rs2_addr = 5'd3; #1;
    check("fill_a0", a0, 64'hA5A5_0000_0000_000A);
    check("fill_x3", rs2, 64'hA5A5_0000_0000_0003);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i); #1;
      check("rst_clear_rs1", rs1, 64'h0);
      check("rst_clear_rs2", rs2, 64'h0);
      check("rst_clear_a0", a0, 64'h0);
    end
    @(negedge clk);
    wr(0, 5'd4, 64'hDEAD);
    tick();
    rs1_addr = 5'd4; #1;
    check("write_in_reset", rs1, 64'h0);
    rst_n = 1'b1;

    // x0 is immutable.
    wr(0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
    check("x0_rs1", rs1, 64'h0);
    check("x0_rs2", rs2, 64'h0);

    // Priority: all three, then LSU+CSR.
    wr(0, 5'd5, 64'h11); wr(1, 5'd6, 64'h22); wr(2, 5'd7, 64'h33);
    tick();
    rs1_addr = 5'd5; rs2_addr = 5'd6; #1;
    check("prio_x5", rs1, 64'h11);
    check("prio_x6", rs2, 64'h0);
    rs1_addr = 5'd7; #1;
    check("prio_x7", rs1, 64'h0);
    wr(1, 5'd6, 64'h22); wr(2, 5'd7, 64'h33);
    tick();
    rs1_addr = 5'd6; rs2_addr = 5'd7; #1;
    check("prio2_x6", rs1, 64'h22);
    check("prio2_x7", rs2, 64'h0);

    // Dual read and a0 tap.
    wr(0, 5'd10, 64'd42); tick();
    wr(2, 5'd3, 64'h1234_5678_9ABC_DEF0); tick();
    rs1_addr = 5'd10; rs2_addr = 5'd3; #1;
    check("dual_rs1", rs1, 64'd42);
    check("dual_rs2", rs2, 64'h1234_5678_9ABC_DEF0);
    check("dual_a0", a0, 64'd42);
    rs2_addr = 5'd10; #1;
    check("same_reg_rs2", rs2, 64'd42);

    // Same-cycle read/write of x8; a0 not bypassed when writing x10.
    wr(0, 5'd8, 64'h1); tick();
    rs1_addr = 5'd8;
    wr(1, 5'd8, 64'h2);
    #1;
`ifdef GPR_BYPASS_EN
    check("rw_before_edge", rs1, 64'h2);
`else
    check("rw_before_edge", rs1, 64'h1);
`endif
    tick();
    #1 check("rw_after_edge", rs1, 64'h2);
    wr(0, 5'd10, 64'd99); #1;
    check("a0_no_bypass", a0, 64'd42);
    tick();
    #1 check("a0_after", a0, 64'd99);

    // Back-to-back writes of x9 from each source.
    rs1_addr = 5'd9;
    wr(0, 5'd9, 64'd1); tick(); #1 check("b2b_exu", rs1, 64'd1);
    wr(1, 5'd9, 64'd2); tick(); #1 check("b2b_lsu", rs1, 64'd2);
    wr(2, 5'd9, 64'd3); tick(); #1 check("b2b_csr", rs1, 64'd3);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rs1_addr = 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
      rd_exu = {$urandom, $urandom}; rdr_exu = 5'($urandom_range(0, 31));
      rd_lsu = {$urandom, $urandom}; rdr_lsu = 5'($urandom_range(0, 31));
      rd_csr = {$urandom, $urandom}; rdr_csr = 5'($urandom_range(0, 31));
      rd_en_exu = 1'($urandom_range(0, 2) == 0);
      rd_en_lsu = 1'($urandom_range(0, 1));
      rd_en_csr = 1'($urandom_range(0, 1));
      check_ports("rand");
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i);
      check_ports("final");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
